// File: rtl/mips_fetch_unit_pkg.sv
// Shared definitions for the MIPS fetch unit: FSM encoding, instruction
// field positions and redirect target widths.
package mips_fetch_unit_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 3;
  localparam int FUNCT_LSB = 0;
  localparam int JTARGET_W = 26;
  localparam int BOFF_W    = 16;

endpackage

// File: rtl/mips_fetch_unit_next_pc_logic.sv
// Combinational next-PC selection for a consumed instruction.
// Jump takes priority over a taken branch; all arithmetic wraps mod 2^32.
module next_pc_logic
  import mips_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] instr_i,
  input  logic        branch_i,
  input  logic        zero_i,
  input  logic        jump_i,
  output logic [31:0] next_pc_o
);

  logic [31:0] jtarget;
  logic [31:0] boff;
  logic [31:0] btarget;

  // Jump keeps the upper region bits of the sequential PC.
  assign jtarget = {pc_plus4_i[31:JTARGET_W+2], instr_i[JTARGET_W-1:0], 2'b00};
  assign boff    = {{(32-BOFF_W-2){instr_i[BOFF_W-1]}}, instr_i[BOFF_W-1:0], 2'b00};
  assign btarget = pc_plus4_i + boff;

  always_comb begin
    next_pc_o = pc_plus4_i;
    if (jump_i)                 next_pc_o = jtarget;
    else if (branch_i && zero_i) next_pc_o = btarget;
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Two-state instruction fetch unit: requests a word, holds it for the
// downstream datapath, then redirects the PC on consume.
module mips_fetch_unit
  import mips_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [3:0]  funct,
  output logic [31:0] pc_plus4,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] retired
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic [31:0]  retired_q;
  logic         req_q;
  logic         vld_q;
  logic [31:0]  pc_plus4_d;
  logic [31:0]  next_pc_d;

  assign pc_plus4_d = pc_q + 32'd4;

  next_pc_logic u_next_pc (
    .pc_plus4_i (pc_plus4_d),
    .instr_i    (instr_q),
    .branch_i   (branch),
    .zero_i     (zero),
    .jump_i     (jump),
    .next_pc_o  (next_pc_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= {RESET_PC[31:2], 2'b00};
      instr_q   <= '0;
      retired_q <= '0;
      req_q     <= 1'b1;
      vld_q     <= 1'b0;
    end else begin
      case (state_q)
        FETCH: if (imem_ack) begin
          instr_q <= imem_rdata;
          state_q <= HOLD;
          req_q   <= 1'b0;
          vld_q   <= 1'b1;
        end
        HOLD: if (instr_ready) begin
          pc_q      <= next_pc_d;
          retired_q <= retired_q + 32'd1;
          state_q   <= FETCH;
          req_q     <= 1'b1;
          vld_q     <= 1'b0;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = {pc_q[31:2], 2'b00};
  assign instr_valid = vld_q;
  assign instr       = instr_q;
  assign op          = instr_q[OP_MSB:OP_LSB];
  assign funct       = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign pc_plus4    = pc_plus4_d;
  assign retired     = retired_q;

endmodule
